board_controller: RTL and testbench

BOARD_CONTROLLER -- requirements
Module: board_controller

---
 rtl/board_controller.sv | 228 ++++++++++++++++++++++
 tb/tb_board_controller.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_controller.sv
// Tic-tac-toe board controller: synchronises move/undo requests, holds the
// nine cells, the player to move and the move count, and locks on a verdict.
// Ports: clk, reset (async active-low), sel[3:0] cell 1..9, place level,
//   undo level (UNDO_EN only), win[1:0] verdict, clear new-game request;
//   pos1..pos9[1:0] cells, turn[1:0], move_cnt[3:0], move_err pulse, locked.
// Optional feature macro: UNDO_EN (one-level undo of the last accepted move).
module board_controller #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sel,
    input  logic       place,
`ifdef UNDO_EN
    input  logic       undo,
`endif
    input  logic [1:0] win,
    input  logic       clear,
    output logic [1:0] pos1,
    output logic [1:0] pos2,
    output logic [1:0] pos3,
    output logic [1:0] pos4,
    output logic [1:0] pos5,
    output logic [1:0] pos6,
    output logic [1:0] pos7,
    output logic [1:0] pos8,
    output logic [1:0] pos9,
    output logic [1:0] turn,
    output logic [3:0] move_cnt,
    output logic       move_err,
    output logic       locked
);

    typedef enum logic [1:0] {
        S_PLAY,
        S_LOCKED,
        S_CLEAR
    } state_t;

    state_t            state, state_n;
    logic [8:0][1:0]   cells, cells_n;
    logic [1:0]        turn_n;
    logic [3:0]        cnt_n;
    logic              err_n;

    // Settle counter: edges are only armed once the synchronisers hold
    // post-reset samples, so a level already high at release never counts.
    logic [1:0]        settle;
    logic              settled;

    logic [SYNC_STAGES-1:0] place_sync;
    logic              place_prev;
    logic              place_armed;
    logic              place_lvl;
    logic              place_req;

`ifdef UNDO_EN
    logic [SYNC_STAGES-1:0] undo_sync;
    logic              undo_prev;
    logic              undo_armed;
    logic              undo_lvl;
    logic              undo_req;
    logic [8:0]        last_hit, last_hit_n;
    logic              undo_ok, undo_ok_n;
`endif

    logic              sel_ok;
    logic [8:0]        hit;
    logic [8:0]        occ;
    logic              can_place;

    assign settled   = (settle == 2'(SYNC_STAGES));
    assign place_lvl = place_sync[SYNC_STAGES-1];
    assign place_req = place_lvl & ~place_prev & place_armed;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            settle      <= '0;
            place_sync  <= '0;
            place_prev  <= 1'b0;
            place_armed <= 1'b0;
        end else begin
            if (!settled) settle <= settle + 2'd1;
            place_sync <= {place_sync[SYNC_STAGES-2:0], place};
            place_prev <= place_lvl;
            if (settled && !place_lvl) place_armed <= 1'b1;
        end
    end

`ifdef UNDO_EN
    assign undo_lvl = undo_sync[SYNC_STAGES-1];
    assign undo_req = undo_lvl & ~undo_prev & undo_armed;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            undo_sync  <= '0;
            undo_prev  <= 1'b0;
            undo_armed <= 1'b0;
        end else begin
            undo_sync <= {undo_sync[SYNC_STAGES-2:0], undo};
            undo_prev <= undo_lvl;
            if (settled && !undo_lvl) undo_armed <= 1'b1;
        end
    end
`endif

    assign sel_ok = (sel != 4'd0) && (sel <= 4'd9);
    assign hit    = sel_ok ? (9'd1 << (sel - 4'd1)) : 9'd0;

    always_comb begin
        occ = '0;
        for (int i = 0; i < 9; i++) occ[i] = |cells[i];
    end

    assign can_place = sel_ok && ((hit & occ) == 9'd0)
                       && (move_cnt != 4'd9);

    always_comb begin
        state_n = state;
        cells_n = cells;
        turn_n  = turn;
        cnt_n   = move_cnt;
        err_n   = 1'b0;
`ifdef UNDO_EN
        last_hit_n = last_hit;
        undo_ok_n  = undo_ok;
`endif
        unique case (state)
            S_PLAY: begin
                if (win != 2'b00) begin
                    state_n = S_LOCKED;
                end else if (place_req) begin
                    if (can_place) begin
                        for (int i = 0; i < 9; i++)
                            if (hit[i]) cells_n[i] = turn;
                        turn_n = ~turn;
                        cnt_n  = move_cnt + 4'd1;
`ifdef UNDO_EN
                        last_hit_n = hit;
                        undo_ok_n  = 1'b1;
`endif
                    end else begin
                        err_n = 1'b1;
                    end
`ifdef UNDO_EN
                end else if (undo_req) begin
                    if (undo_ok && move_cnt != 4'd0) begin
                        for (int i = 0; i < 9; i++)
                            if (last_hit[i]) cells_n[i] = 2'b00;
                        turn_n    = ~turn;
                        cnt_n     = move_cnt - 4'd1;
                        undo_ok_n = 1'b0;
                    end else begin
                        err_n = 1'b1;
                    end
`endif
                end
            end
            S_LOCKED: begin
`ifdef UNDO_EN
                if (undo_req) err_n = 1'b1;
`endif
            end
            S_CLEAR: begin
                state_n = S_PLAY;
                cells_n = '0;
                turn_n  = 2'b01;
                cnt_n   = 4'd0;
`ifdef UNDO_EN
                undo_ok_n = 1'b0;
`endif
            end
            default: state_n = S_PLAY;
        endcase
        // New-game request overrides anything decided above.
        if (clear) begin
            state_n = S_CLEAR;
            cells_n = '0;
            turn_n  = 2'b01;
            cnt_n   = 4'd0;
            err_n   = 1'b0;
`ifdef UNDO_EN
            undo_ok_n = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_PLAY;
            cells    <= '0;
            turn     <= 2'b01;
            move_cnt <= 4'd0;
            move_err <= 1'b0;
        end else begin
            state    <= state_n;
            cells    <= cells_n;
            turn     <= turn_n;
            move_cnt <= cnt_n;
            move_err <= err_n;
        end
    end

`ifdef UNDO_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_hit <= '0;
            undo_ok  <= 1'b0;
        end else begin
            last_hit <= last_hit_n;
            undo_ok  <= undo_ok_n;
        end
    end
`endif

    assign locked = (state == S_LOCKED);

    assign pos1 = cells[0];
    assign pos2 = cells[1];
    assign pos3 = cells[2];
    assign pos4 = cells[3];
    assign pos5 = cells[4];
    assign pos6 = cells[5];
    assign pos7 = cells[6];
    assign pos8 = cells[7];
    assign pos9 = cells[8];

endmodule

// File: tb/tb_board_controller.sv
// Self-checking bench for board_controller: random and directed moves
// compared against a game-level model of the board.
module tb_board_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] sel = 4'd0;
    logic       place = 1'b0;
    logic       undo = 1'b0;
    logic [1:0] win = 2'b00;
    logic       clear = 1'b0;
    logic [1:0] pos1, pos2, pos3, pos4, pos5;
    logic [1:0] pos6, pos7, pos8, pos9;
    logic [1:0] turn;
    logic [3:0] move_cnt;
    logic       move_err;
    logic       locked;

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;
    int err_long = 0;
    bit err_prev = 1'b0;

    int m_cell[9];
    int m_turn;
    int m_cnt;
    bit m_locked;
    int m_last;
    bit m_uv;

    board_controller dut (
        .clk(clk),
        .reset(reset),
        .sel(sel),
        .place(place),
`ifdef UNDO_EN
        .undo(undo),
`endif
        .win(win),
        .clear(clear),
        .pos1(pos1), .pos2(pos2), .pos3(pos3),
        .pos4(pos4), .pos5(pos5), .pos6(pos6),
        .pos7(pos7), .pos8(pos8), .pos9(pos9),
        .turn(turn),
        .move_cnt(move_cnt),
        .move_err(move_err),
        .locked(locked)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (move_err === 1'b1) begin
            err_pulses++;
            if (err_prev) err_long++;
        end
        err_prev = (move_err === 1'b1);
    end

    function automatic void m_new_game();
        for (int i = 0; i < 9; i++) m_cell[i] = 0;
        m_turn = 1;
        m_cnt = 0;
        m_locked = 1'b0;
        m_uv = 1'b0;
        m_last = 0;
    endfunction

    task automatic check_all(input string name);
        logic [17:0] exp_b, act_b;
        for (int i = 0; i < 9; i++) exp_b[2*i +: 2] = 2'(m_cell[i]);
        act_b = {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};
        checks++;
        if (act_b !== exp_b) begin
            errors++;
            $display("FAIL %s board: got %h expected %h", name, act_b, exp_b);
        end
        checks++;
        if (turn !== 2'(m_turn)) begin
            errors++;
            $display("FAIL %s turn: got %0d expected %0d", name, turn, m_turn);
        end
        checks++;
        if (move_cnt !== 4'(m_cnt)) begin
            errors++;
            $display("FAIL %s move_cnt: got %0d expected %0d",
                     name, move_cnt, m_cnt);
        end
        checks++;
        if (locked !== m_locked) begin
            errors++;
            $display("FAIL %s locked: got %0b expected %0b",
                     name, locked, m_locked);
        end
    endtask

    task automatic do_place(input logic [3:0] s, input string name);
        int e0;
        int exp_err;
        exp_err = 0;
        if (!m_locked) begin
            if (s < 1 || s > 9) exp_err = 1;
            else if (m_cell[s-1] != 0) exp_err = 1;
            else begin
                m_cell[s-1] = m_turn;
                m_turn = 3 - m_turn;
                m_cnt++;
                m_last = s;
                m_uv = 1'b1;
            end
        end
        e0 = err_pulses;
        @(negedge clk);
        sel = s;
        place = 1'b1;
        repeat (6) @(negedge clk);
        place = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (err_pulses - e0 !== exp_err) begin
            errors++;
            $display("FAIL %s move_err pulses: got %0d expected %0d",
                     name, err_pulses - e0, exp_err);
        end
        check_all(name);
    endtask

    task automatic do_undo(input string name);
        int e0;
        int exp_err;
        exp_err = 0;
        if (m_locked || !m_uv || m_cnt == 0) exp_err = 1;
        else begin
            m_cell[m_last-1] = 0;
            m_turn = 3 - m_turn;
            m_cnt--;
            m_uv = 1'b0;
        end
        e0 = err_pulses;
        @(negedge clk);
        undo = 1'b1;
        repeat (6) @(negedge clk);
        undo = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (err_pulses - e0 !== exp_err) begin
            errors++;
            $display("FAIL %s undo move_err pulses: got %0d expected %0d",
                     name, err_pulses - e0, exp_err);
        end
        check_all(name);
    endtask

    task automatic do_lock(input logic [1:0] w);
        @(negedge clk);
        win = w;
        repeat (2) @(negedge clk);
        m_locked = 1'b1;
        check_all("lock");
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        win = 2'b00;
        @(negedge clk);
        clear = 1'b0;
        repeat (2) @(negedge clk);
        m_new_game();
        check_all("clear");
    endtask

    task automatic test_reset();
        m_new_game();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_all("in_reset");
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check_all("after_reset");
    endtask

    task automatic test_basic();
        do_place(4'd5, "basic5");
        do_place(4'd1, "basic1");
    endtask

    task automatic test_reject();
        do_clear();
        do_place(4'd5, "rej_first");
        do_place(4'd5, "rej_occupied");
        do_place(4'd0, "rej_sel0");
        do_place(4'd12, "rej_sel12");
    endtask

    task automatic test_lock_clear();
        do_place(4'd2, "pre_lock");
        do_lock(2'b01);
        do_place(4'd9, "locked_place");
        do_clear();
    endtask

    task automatic test_full();
        int order[9] = '{1, 2, 3, 5, 4, 6, 8, 7, 9};
        for (int i = 0; i < 9; i++) do_place(4'(order[i]), "fill");
        do_place(4'd5, "full_reject");
        do_place(4'd10, "full_badsel");
        do_clear();
    endtask

    task automatic test_undo();
        do_place(4'd3, "undo_place3");
        do_undo("undo_first");
        do_undo("undo_second");
        do_place(4'd4, "undo_p4");
        do_place(4'd6, "undo_p6");
        do_undo("undo_p6_back");
        do_lock(2'b11);
        do_undo("undo_locked");
        do_clear();
    endtask

    task automatic test_reset_held();
        do_place(4'd1, "rh_a");
        do_place(4'd2, "rh_b");
        @(negedge clk);
        sel = 4'd7;
        place = 1'b1;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        m_new_game();
        check_all("rh_in_reset");
        reset = 1'b1;
        repeat (10) @(negedge clk);
        check_all("rh_held_high");
        place = 1'b0;
        repeat (6) @(negedge clk);
        check_all("rh_released");
        do_place(4'd7, "rh_fresh_edge");
    endtask

    task automatic test_random();
        int r;
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 11);
            if (m_cnt == 9 || r == 0) do_clear();
            else if (r == 1 && !m_locked) do_lock(2'($urandom_range(1, 3)));
`ifdef UNDO_EN
            else if (r == 2) do_undo("rnd_undo");
`endif
            else do_place(4'($urandom_range(0, 15)), "rnd_place");
        end
        do_clear();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reject();
        test_lock_clear();
        test_full();
`ifdef UNDO_EN
        test_undo();
`endif
        test_reset_held();
        test_random();
        checks++;
        if (err_long !== 0) begin
            errors++;
            $display("FAIL err_width: got %0d multi-cycle pulses expected 0",
                     err_long);
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
